intr_ctrl: RTL and testbench



---
 rtl/intr_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl -- multi-source interrupt controller.
//
// Latches up to NUM_SRC peripheral interrupt lines into a pending register.
// Each source can be enabled or disabled and set to level or edge mode.
// Among the enabled pending sources, the lowest index wins. The controller
// raises a single request with that source ID to the trap logic. When the
// core takes the trap, it sends a one-cycle clear pulse back to the winning
// peripheral. It then holds off further requests until mret.
//
// Optional build macro: INTR_CTRL_CNT_EN adds per-source saturating ack
// counters, readable at config index 0x4+i. Without the macro, no counter
// flops exist and those indices read 0.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   src_intr_i   raw interrupt lines, one per source
//   src_clear_o  one-cycle clear pulse to the accepted source
//   cfg_we_i     config write strobe
//   cfg_addr_i   config register index
//   cfg_wdata_i  config write data
//   cfg_rdata_o  config read data, combinational on cfg_addr_i
//   intr_req_o   interrupt request to the trap logic
//   intr_id_o    ID of the requesting (or in-service) source
//   intr_ack_i   trap taken by the core
//   is_mret_i    mret executed, ends service
//   busy_o       high while requesting or in service
//
// Config map (bits above NUM_SRC read 0):
//   0x0 ENABLE rw | 0x1 MODE rw (1=edge) | 0x2 PENDING r/W1C
//   0x3 STATUS r (bit31=busy, [4:0]=id) | 0x4+i counter i (optional)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request outstanding, arbitrating enabled pending sources
// REQ     | intr_req_o high with a fixed ID, waiting for ack or withdrawal
// SERVICE | trap taken, handler running, waiting for mret

module intr_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_intr_i,
    output logic [NUM_SRC-1:0] src_clear_o,
    input  logic               cfg_we_i,
    input  logic [5:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic               intr_req_o,
    output logic [4:0]         intr_id_o,
    input  logic               intr_ack_i,
    input  logic               is_mret_i,
    output logic               busy_o
);

    if (NUM_SRC < 1 || NUM_SRC > 28 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
        $error("intr_ctrl: NUM_SRC must be 1..28 and CNT_W 1..32");
    end

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         id_q, id_d, win_id;
    logic [NUM_SRC-1:0] enable_q, mode_q, pending_q, pending_d, src_prev_q;
    logic [NUM_SRC-1:0] clear_q, clear_d;
    logic [NUM_SRC-1:0] cand, id_onehot, ack_clr, w1c, set_v;
    logic               withdrawn;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata_i;

    assign cand      = pending_q & enable_q;
    assign id_onehot = NUM_SRC'(1) << id_q;
    assign withdrawn = ((pending_q & enable_q & id_onehot) == '0);
    assign ack_clr   = (state_q == REQ && intr_ack_i) ? id_onehot : '0;
    assign w1c       = (cfg_we_i && cfg_addr_i == 6'd2) ? cfg_wdata_i[NUM_SRC-1:0] : '0;
    assign set_v     = (mode_q & src_intr_i & ~src_prev_q) | (~mode_q & src_intr_i);
    // Set after clear so a new event in the clearing cycle is not lost.
    assign pending_d = (pending_q & ~(w1c | ack_clr)) | set_v;

    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) win_id = 5'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q   <= '0;
            mode_q     <= '0;
            pending_q  <= '0;
            src_prev_q <= '0;
        end else begin
            if (cfg_we_i && cfg_addr_i == 6'd0) enable_q <= cfg_wdata_i[NUM_SRC-1:0];
            if (cfg_we_i && cfg_addr_i == 6'd1) mode_q   <= cfg_wdata_i[NUM_SRC-1:0];
            pending_q  <= pending_d;
            src_prev_q <= src_intr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            clear_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            clear_q <= clear_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clear_d = '0;
        case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    state_d = REQ;
                    id_d    = win_id;
                end
            end
            REQ: begin
                // Ack beats a simultaneous withdrawal.
                if (intr_ack_i) begin
                    state_d = SERVICE;
                    clear_d = id_onehot;
                end else if (withdrawn) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (is_mret_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign src_clear_o = clear_q;
    assign intr_req_o  = (state_q == REQ);
    assign intr_id_o   = id_q;
    assign busy_o      = (state_q != IDLE);

`ifdef INTR_CTRL_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_SRC];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_we_i && cfg_addr_i == 6'(4 + i)) begin
                    cnt_q[i] <= '0;
                end else if (ack_clr[i] && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            6'd0: cfg_rdata_o = 32'(enable_q);
            6'd1: cfg_rdata_o = 32'(mode_q);
            6'd2: cfg_rdata_o = 32'(pending_q);
            6'd3: cfg_rdata_o = {busy_o, 26'd0, id_q};
            default: cfg_rdata_o = '0;
        endcase
`ifdef INTR_CTRL_CNT_EN
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cfg_addr_i == 6'(4 + i)) cfg_rdata_o = 32'(cnt_q[i]);
        end
`endif
    end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    localparam int NSRC = 8;
`ifdef INTR_CTRL_CNT_EN
    localparam int CW = 2;
    localparam logic [31:0] CNT1_SAT = 32'd3;
    localparam logic [31:0] CNT0_EXP = 32'd2;
`else
    localparam int CW = 16;
    localparam logic [31:0] CNT1_SAT = 32'd0;
    localparam logic [31:0] CNT0_EXP = 32'd0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [NSRC-1:0] src_intr_i = '0;
    logic [NSRC-1:0] src_clear_o;
    logic            cfg_we_i = 1'b0;
    logic [5:0]      cfg_addr_i = '0;
    logic [31:0]     cfg_wdata_i = '0;
    logic [31:0]     cfg_rdata_o;
    logic            intr_req_o;
    logic [4:0]      intr_id_o;
    logic            intr_ack_i = 1'b0;
    logic            is_mret_i = 1'b0;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    logic [4:0]      exp_req_q [$];
    logic [NSRC-1:0] exp_clr_q [$];
    logic            req_prev = 1'b0;
    logic [4:0]      e_id;
    logic [NSRC-1:0] e_clr;

    intr_ctrl #(.NUM_SRC(NSRC), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .src_intr_i(src_intr_i), .src_clear_o(src_clear_o),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata_o), .intr_req_o(intr_req_o), .intr_id_o(intr_id_o),
        .intr_ack_i(intr_ack_i), .is_mret_i(is_mret_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    // Monitor: every new request and every clear pulse must match the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (intr_req_o && !req_prev) begin
                checks++;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected actual_id=%0d expected=none", intr_id_o);
                end else begin
                    e_id = exp_req_q.pop_front();
                    if (intr_id_o !== e_id) begin
                        errors++;
                        $display("FAIL req_id actual=%0d expected=%0d", intr_id_o, e_id);
                    end
                end
            end
            if (src_clear_o != '0) begin
                checks++;
                if (exp_clr_q.size() == 0) begin
                    errors++;
                    $display("FAIL clr_unexpected actual=0x%0h expected=none", src_clear_o);
                end else begin
                    e_clr = exp_clr_q.pop_front();
                    if (src_clear_o !== e_clr) begin
                        errors++;
                        $display("FAIL clr_mask actual=0x%0h expected=0x%0h", src_clear_o, e_clr);
                    end
                end
            end
        end
        req_prev <= intr_req_o;
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    task automatic cfg_read(input logic [5:0] addr, output logic [31:0] data);
        cfg_addr_i = addr;
        #1;
        data = cfg_rdata_o;
    endtask

    task automatic expect_serve(input int id);
        exp_req_q.push_back(5'(id));
        exp_clr_q.push_back(NSRC'(1) << id);
    endtask

    task automatic pulse(input logic [NSRC-1:0] m);
        src_intr_i = m;
        tick();
        src_intr_i = '0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!intr_req_o && n < 20) begin
            tick();
            n++;
        end
        if (!intr_req_o) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=0 expected=1");
        end
    endtask

    task automatic serve();
        wait_req();
        repeat ($urandom_range(0, 2)) tick();
        intr_ack_i = 1'b1;
        tick();
        intr_ack_i = 1'b0;
        tick();
        repeat ($urandom_range(0, 2)) tick();
        is_mret_i = 1'b1;
        tick();
        is_mret_i = 1'b0;
    endtask

    logic [31:0]     rd;
    logic [NSRC-1:0] m_pend, m_prev, m_en, m_w1c, v;

    initial begin
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        // Reset state
        chk("rst_req", 32'(intr_req_o), 0);
        chk("rst_id", 32'(intr_id_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_clr", 32'(src_clear_o), 0);
        cfg_read(6'd0, rd); chk("rst_enable", rd, 0);
        cfg_read(6'd2, rd); chk("rst_pending", rd, 0);
        cfg_read(6'd3, rd); chk("rst_status", rd, 0);
        tick();
        cfg_write(6'd32, 32'hFFFF_FFFF);
        cfg_read(6'd32, rd); chk("unmapped_read", rd, 0);
        tick();

        // Single edge, exact latency and handshake
        cfg_write(6'd0, 32'hFF);
        cfg_write(6'd1, 32'hFF);
        cfg_read(6'd0, rd); chk("enable_rb", rd, 32'hFF);
        tick();
        expect_serve(3);
        src_intr_i = 8'h08;
        tick();
        src_intr_i = '0;
        chk("s1_lat1_req", 32'(intr_req_o), 0);
        tick();
        chk("s1_lat2_req", 32'(intr_req_o), 1);
        chk("s1_id", 32'(intr_id_o), 3);
        cfg_read(6'd3, rd); chk("s1_status", rd, 32'h8000_0003);
        tick();
        intr_ack_i = 1'b1;
        tick();
        intr_ack_i = 1'b0;
        chk("s1_clr", 32'(src_clear_o), 32'h08);
        chk("s1_busy_svc", 32'(busy_o), 1);
        chk("s1_req_svc", 32'(intr_req_o), 0);
        cfg_read(6'd2, rd); chk("s1_pending", rd, 0);
        tick();
        chk("s1_clr_once", 32'(src_clear_o), 0);
        is_mret_i = 1'b1;
        tick();
        is_mret_i = 1'b0;
        chk("s1_busy_end", 32'(busy_o), 0);

        // Two simultaneous edges: lower index first, no repeat
        expect_serve(2);
        expect_serve(5);
        pulse(8'h24);
        serve();
        serve();
        repeat (10) tick();
        chk("s2_no_rereq", 32'(intr_req_o), 0);
        cfg_read(6'd2, rd); chk("s2_pending", rd, 0);
        tick();

        // Level source held high through ack
        cfg_write(6'd1, 32'hFE);
        exp_req_q.push_back(5'd0);
        exp_clr_q.push_back(8'h01);
        exp_req_q.push_back(5'd0);
        exp_clr_q.push_back(8'h01);
        src_intr_i = 8'h01;
        wait_req();
        intr_ack_i = 1'b1;
        tick();
        intr_ack_i = 1'b0;
        cfg_read(6'd2, rd); chk("s3_pending_reset", rd, 32'h01);
        tick();
        is_mret_i = 1'b1;
        tick();
        is_mret_i = 1'b0;
        chk("s3_idle_after_mret", 32'(intr_req_o), 0);
        tick();
        chk("s3_rereq", 32'(intr_req_o), 1);
        chk("s3_rereq_id", 32'(intr_id_o), 0);
        src_intr_i = '0;
        intr_ack_i = 1'b1;
        tick();
        intr_ack_i = 1'b0;
        tick();
        is_mret_i = 1'b1;
        tick();
        is_mret_i = 1'b0;
        cfg_read(6'd2, rd); chk("s3_pending_end", rd, 0);
        tick();
        cfg_write(6'd1, 32'hFF);

        // Withdrawal by disabling the requesting source
        exp_req_q.push_back(5'd4);
        pulse(8'h10);
        wait_req();
        chk("s4_id", 32'(intr_id_o), 4);
        cfg_write(6'd0, 32'hEF);
        for (int n = 0; n < 4 && intr_req_o; n++) tick();
        chk("s4_dropped", 32'(intr_req_o), 0);
        chk("s4_idle", 32'(busy_o), 0);
        cfg_read(6'd2, rd); chk("s4_pending_kept", rd, 32'h10);
        tick();
        expect_serve(4);
        cfg_write(6'd0, 32'hFF);
        serve();

        // Ack counters (saturating in the counter build, absent otherwise)
        for (int k = 0; k < 4; k++) begin
            expect_serve(1);
            pulse(8'h02);
            serve();
        end
        cfg_read(6'd5, rd); chk("cnt1_sat", rd, CNT1_SAT);
        cfg_read(6'd4, rd); chk("cnt0", rd, CNT0_EXP);
        tick();
        cfg_write(6'd5, 32'h0);
        cfg_read(6'd5, rd); chk("cnt1_cleared", rd, 0);
        tick();

        // Async reset mid-service, then a stray mret
        expect_serve(6);
        pulse(8'h40);
        wait_req();
        intr_ack_i = 1'b1;
        tick();
        intr_ack_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("s5_rst_req", 32'(intr_req_o), 0);
        chk("s5_rst_busy", 32'(busy_o), 0);
        chk("s5_rst_id", 32'(intr_id_o), 0);
        chk("s5_rst_clr", 32'(src_clear_o), 0);
        tick();
        rst_i = 1'b0;
        tick();
        is_mret_i = 1'b1;
        tick();
        is_mret_i = 1'b0;
        tick();
        chk("s5_mret_busy", 32'(busy_o), 0);
        chk("s5_mret_req", 32'(intr_req_o), 0);
        cfg_read(6'd0, rd); chk("s5_enable_reset", rd, 0);
        tick();

        // Randomized rounds against a set-based model
        cfg_write(6'd1, 32'hFF);
        m_pend = '0;
        m_prev = '0;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = NSRC'($urandom);
                m_pend |= v & ~m_prev;
                m_prev = v;
                src_intr_i = v;
                tick();
            end
            src_intr_i = '0;
            m_prev = '0;
            tick();
            m_w1c = NSRC'($urandom) & NSRC'($urandom);
            cfg_write(6'd2, 32'(m_w1c));
            m_pend &= ~m_w1c;
            m_en = NSRC'($urandom);
            for (int i = 0; i < NSRC; i++) begin
                if (m_pend[i] && m_en[i]) expect_serve(i);
            end
            cfg_write(6'd0, 32'(m_en));
            for (int i = 0; i < NSRC; i++) begin
                if (m_pend[i] && m_en[i]) serve();
            end
            cfg_write(6'd0, 32'h0);
            m_pend &= ~m_en;
            cfg_read(6'd2, rd); chk("rnd_pending", rd, 32'(m_pend));
            tick();
        end

        repeat (5) tick();
        chk("req_queue_empty", 32'(exp_req_q.size()), 0);
        chk("clr_queue_empty", 32'(exp_clr_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
